// File: rtl/avalon_displays7seg_pkg.sv
// -----------------------------------------------------------------------------
// avalon_displays7seg_pkg
//
// Shared definitions for the multiplexed seven-segment display slave:
//   - word offsets of the register map
//   - CTRL bit positions and the CTRL reset value
//   - the 16-entry hexadecimal glyph table (logical form, 1 = lit, bit0 = a)
//   - count_width(), the width needed to hold a counter running 0..n-1
// -----------------------------------------------------------------------------
package avalon_displays7seg_pkg;

    // Register word offsets
    localparam int unsigned REG_CTRL       = 32'd0;
    localparam int unsigned REG_BLANK      = 32'd1;
    localparam int unsigned REG_BLINK      = 32'd2;
    localparam int unsigned REG_MODE       = 32'd3;
    localparam int unsigned REG_DIGIT_BASE = 32'd4;

    // CTRL bit indices
    localparam int unsigned CTRL_ENABLE_BIT   = 32'd0;
    localparam int unsigned CTRL_BLINK_EN_BIT = 32'd1;
    localparam int unsigned CTRL_SCAN_EN_BIT  = 32'd2;

    // ENABLE and SCAN_EN set, BLINK_EN clear
    localparam logic [2:0] CTRL_RESET = 3'b101;

    // Hex glyphs, entry 15 first so that HEX_GLYPHS[n] is the glyph of n
    localparam logic [15:0][6:0] HEX_GLYPHS = {
        7'h71,  // F
        7'h79,  // E
        7'h5E,  // d
        7'h39,  // C
        7'h7C,  // b
        7'h77,  // A
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    // Bits needed for a counter that runs 0..n-1 (never less than 1)
    function automatic int unsigned count_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        for (int b = 0; b < 31; b++) begin
            if ((64'd1 << w) < 64'(n)) begin
                w = w + 32'd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/avalon_displays7seg_mux_seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
//
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit value 0..F
//   glyph  : logical segment pattern, 1 = lit, bit0 = segment a .. bit6 = g
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import avalon_displays7seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Table lookup of the glyph for the nibble
    assign glyph = HEX_GLYPHS[nibble];

endmodule

// File: rtl/avalon_displays7seg_mux.sv
// -----------------------------------------------------------------------------
// avalon_displays7seg_mux
//
// Avalon-MM slave driving NUM_DIGITS seven-segment digits, both as direct
// per-digit outputs and as a time-multiplexed scan bus. Each digit can be
// hex-decoded or driven with raw segments, blanked, or blinked in hardware.
//
// Ports:
//   clk                clock, all state changes on its rising edge
//   reset_n            synchronous active-low reset
//   avs_address        word address
//   avs_write          write strobe
//   avs_writedata      write data (unused bits discarded)
//   avs_read           read strobe
//   avs_readdata       registered read data, loaded on the read edge
//   avs_readdatavalid  high for the cycle after an accepted read
//   seg_out            direct outputs, digit i at [7i+6:7i], bit0 = segment a
//   scan_seg           multiplexed segment bus
//   scan_sel           one-hot digit select for the scan bus
//
// All display outputs are physical levels: with SEG_ACTIVE_LOW=1 a lit
// segment and a selected digit are driven 0.
// -----------------------------------------------------------------------------
module avalon_displays7seg_mux
    import avalon_displays7seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 32'd8,
    parameter int unsigned ADDR_W         = 32'd5,
    parameter int unsigned SCAN_DIV       = 32'd50000,
    parameter int unsigned BLINK_DIV      = 32'd12500000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         avs_address,
    input  logic                      avs_write,
    input  logic [31:0]               avs_writedata,
    input  logic                      avs_read,
    output logic [31:0]               avs_readdata,
    output logic                      avs_readdatavalid,
    output logic [7*NUM_DIGITS-1:0]   seg_out,
    output logic [6:0]                scan_seg,
    output logic [NUM_DIGITS-1:0]     scan_sel
);

    localparam int unsigned SCAN_W  = count_width(SCAN_DIV);
    localparam int unsigned BLINK_W = count_width(BLINK_DIV);
    localparam int unsigned IDX_W   = count_width(NUM_DIGITS);

    localparam logic [NUM_DIGITS-1:0] DIG_ZERO = {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] DIG_ONES = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1'b1);

    // Physical levels of the states that are known without computation
    localparam logic [6:0]            OFF_PHYS  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0]            ZERO_PHYS = SEG_ACTIVE_LOW ? ~HEX_GLYPHS[0] : HEX_GLYPHS[0];
    localparam logic [NUM_DIGITS-1:0] SEL_NONE  = SEG_ACTIVE_LOW ? DIG_ONES : DIG_ZERO;
    localparam logic [NUM_DIGITS-1:0] SEL_FIRST = SEG_ACTIVE_LOW ? ~SEL_ONE : SEL_ONE;

    // Logical lit pattern to physical segment levels
    function automatic logic [6:0] to_phys(input logic [6:0] lit);
        return SEG_ACTIVE_LOW ? ~lit : lit;
    endfunction

    // Logical one-hot select to physical select levels
    function automatic logic [NUM_DIGITS-1:0] sel_phys(input logic [NUM_DIGITS-1:0] onehot);
        return SEG_ACTIVE_LOW ? ~onehot : onehot;
    endfunction

    // ---------------------------------------------------------------- state
    logic [2:0]             ctrl_r;
    logic [NUM_DIGITS-1:0]  blank_r;
    logic [NUM_DIGITS-1:0]  blink_r;
    logic [NUM_DIGITS-1:0]  mode_r;
    logic [6:0]             digit_r [NUM_DIGITS];

    logic [BLINK_W-1:0]     blink_cnt_r;
    logic                   blink_phase_r;

    logic [SCAN_W-1:0]      scan_div_r;
    logic [IDX_W-1:0]       scan_idx_r;
    logic [NUM_DIGITS-1:0]  scan_sel_r;
    logic [6:0]             scan_seg_r;

    logic [7*NUM_DIGITS-1:0] seg_out_r;
    logic [31:0]            readdata_r;
    logic                   readdatavalid_r;

    // ---------------------------------------------------------- combinational
    logic                   wr_ctrl_s;
    logic                   wr_blank_s;
    logic                   wr_blink_s;
    logic                   wr_mode_s;
    logic [NUM_DIGITS-1:0]  wr_digit_s;

    logic [31:0]            digit_rd_s;
    logic [31:0]            rdata_s;

    logic [6:0]             hex_s  [NUM_DIGITS];
    logic [6:0]             lit_s  [NUM_DIGITS];
    logic [6:0]             phys_s [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] phys_flat_s;

    logic                   scan_en_s;
    logic [SCAN_W-1:0]      scan_div_nxt_s;
    logic [IDX_W-1:0]       scan_idx_nxt_s;

    // Upper write-data bits carry no information for any register
    logic                   unused_wdata_s;
    assign unused_wdata_s = ^avs_writedata[31:7];

    // Per-digit hex decoders; the scan path reuses their results
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_hex_decode u_dec (
            .nibble (digit_r[g][3:0]),
            .glyph  (hex_s[g])
        );
    end

    // Write strobes per register
    always_comb begin
        wr_ctrl_s  = avs_write && (avs_address == ADDR_W'(REG_CTRL));
        wr_blank_s = avs_write && (avs_address == ADDR_W'(REG_BLANK));
        wr_blink_s = avs_write && (avs_address == ADDR_W'(REG_BLINK));
        wr_mode_s  = avs_write && (avs_address == ADDR_W'(REG_MODE));
        wr_digit_s = DIG_ZERO;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            wr_digit_s[i] = avs_write && (avs_address == ADDR_W'(REG_DIGIT_BASE + i));
        end
    end

    // Register file
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_r  <= CTRL_RESET;
            blank_r <= DIG_ZERO;
            blink_r <= DIG_ZERO;
            mode_r  <= DIG_ONES;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_r[i] <= 7'h00;
            end
        end else begin
            if (wr_ctrl_s) begin
                ctrl_r <= avs_writedata[2:0];
            end
            if (wr_blank_s) begin
                blank_r <= avs_writedata[NUM_DIGITS-1:0];
            end
            if (wr_blink_s) begin
                blink_r <= avs_writedata[NUM_DIGITS-1:0];
            end
            if (wr_mode_s) begin
                mode_r <= avs_writedata[NUM_DIGITS-1:0];
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_digit_s[i]) begin
                    digit_r[i] <= avs_writedata[6:0];
                end
            end
        end
    end

    // Readback mux; digits are OR-selected so unmapped offsets read 0
    always_comb begin
        digit_rd_s = 32'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_rd_s = digit_rd_s |
                ({25'h0, digit_r[i]} & {32{avs_address == ADDR_W'(REG_DIGIT_BASE + i)}});
        end
        case (avs_address)
            ADDR_W'(REG_CTRL):  rdata_s = {29'h0, ctrl_r};
            ADDR_W'(REG_BLANK): rdata_s = {{(32-NUM_DIGITS){1'b0}}, blank_r};
            ADDR_W'(REG_BLINK): rdata_s = {{(32-NUM_DIGITS){1'b0}}, blink_r};
            ADDR_W'(REG_MODE):  rdata_s = {{(32-NUM_DIGITS){1'b0}}, mode_r};
            default:            rdata_s = digit_rd_s;
        endcase
    end

    // Read data and valid; a concurrent write is seen only by later reads
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata_r      <= 32'h0;
            readdatavalid_r <= 1'b0;
        end else begin
            readdatavalid_r <= avs_read;
            if (avs_read) begin
                readdata_r <= rdata_s;
            end
        end
    end

    // Blink divider: phase toggles every BLINK_DIV cycles, independent of BLINK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 32'd1)) begin
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + BLINK_W'(1'b1);
        end
    end

    // Per-digit lit pattern and its physical level
    always_comb begin
        phys_flat_s = {(7*NUM_DIGITS){1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!ctrl_r[CTRL_ENABLE_BIT] || blank_r[i] ||
                (ctrl_r[CTRL_BLINK_EN_BIT] && blink_r[i] && blink_phase_r)) begin
                lit_s[i] = 7'h00;
            end else if (mode_r[i]) begin
                lit_s[i] = hex_s[i];
            end else begin
                lit_s[i] = digit_r[i];
            end
            phys_s[i]             = to_phys(lit_s[i]);
            phys_flat_s[7*i +: 7] = phys_s[i];
        end
    end

    // Direct outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_out_r <= {NUM_DIGITS{ZERO_PHYS}};
        end else begin
            seg_out_r <= phys_flat_s;
        end
    end

    // Scan sequencing: divider and index are parked at 0 while disabled
    always_comb begin
        scan_en_s = ctrl_r[CTRL_SCAN_EN_BIT];
        if (!scan_en_s) begin
            scan_div_nxt_s = {SCAN_W{1'b0}};
            scan_idx_nxt_s = {IDX_W{1'b0}};
        end else if (scan_div_r == SCAN_W'(SCAN_DIV - 32'd1)) begin
            scan_div_nxt_s = {SCAN_W{1'b0}};
            if (scan_idx_r == IDX_W'(NUM_DIGITS - 32'd1)) begin
                scan_idx_nxt_s = {IDX_W{1'b0}};
            end else begin
                scan_idx_nxt_s = scan_idx_r + IDX_W'(1'b1);
            end
        end else begin
            scan_div_nxt_s = scan_div_r + SCAN_W'(1'b1);
            scan_idx_nxt_s = scan_idx_r;
        end
    end

    // Scan outputs registered from the next index so select and segments stay aligned
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_div_r <= {SCAN_W{1'b0}};
            scan_idx_r <= {IDX_W{1'b0}};
            scan_sel_r <= SEL_FIRST;
            scan_seg_r <= ZERO_PHYS;
        end else begin
            scan_div_r <= scan_div_nxt_s;
            scan_idx_r <= scan_idx_nxt_s;
            if (scan_en_s) begin
                scan_sel_r <= sel_phys(SEL_ONE << scan_idx_nxt_s);
                scan_seg_r <= phys_s[scan_idx_nxt_s];
            end else begin
                scan_sel_r <= SEL_NONE;
                scan_seg_r <= OFF_PHYS;
            end
        end
    end

    assign avs_readdata      = readdata_r;
    assign avs_readdatavalid = readdatavalid_r;
    assign seg_out           = seg_out_r;
    assign scan_seg          = scan_seg_r;
    assign scan_sel          = scan_sel_r;

endmodule

// File: tb/tb_avalon_displays7seg_mux.sv
// -----------------------------------------------------------------------------
// Self-checking bench for avalon_displays7seg_mux (4 digits, SCAN_DIV=3,
// BLINK_DIV=4, active-low). A behavioural model holds the register contents;
// display and scan expectations are derived from the count of clock edges
// since reset (blink phase) and since scanning was last switched on.
// -----------------------------------------------------------------------------
module tb_avalon_displays7seg_mux;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int SD = 3;
    localparam int BD = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [AW-1:0]   avs_address = '0;
    logic            avs_write = 1'b0;
    logic [31:0]     avs_writedata = 32'h0;
    logic            avs_read = 1'b0;
    logic [31:0]     avs_readdata;
    logic            avs_readdatavalid;
    logic [7*N-1:0]  seg_out;
    logic [6:0]      scan_seg;
    logic [N-1:0]    scan_sel;

    always #5 clk = ~clk;

    avalon_displays7seg_mux #(
        .NUM_DIGITS     (N),
        .ADDR_W         (AW),
        .SCAN_DIV       (SD),
        .BLINK_DIV      (BD),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_read          (avs_read),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .seg_out           (seg_out),
        .scan_seg          (scan_seg),
        .scan_sel          (scan_sel)
    );

    // Edges since the last reset edge (0 right after a reset edge)
    int edge_cnt = 0;
    always @(posedge clk) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    // Model state
    logic [2:0] m_ctrl;
    logic [3:0] m_blank, m_blink, m_mode;
    logic [6:0] m_digit [N];
    int         scan_ref;
    int         n_tests = 0;
    int         n_fail  = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   rexp;
    } vec_t;
    vec_t vecs [10];

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ctrl  = 3'h5;
        m_blank = 4'h0;
        m_blink = 4'h0;
        m_mode  = 4'hF;
        for (int i = 0; i < N; i++) m_digit[i] = 7'h00;
        scan_ref = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        if (a == 0)                return {29'h0, m_ctrl};
        else if (a == 1)           return {28'h0, m_blank};
        else if (a == 2)           return {28'h0, m_blink};
        else if (a == 3)           return {28'h0, m_mode};
        else if (a >= 4 && a < 8)  return {25'h0, m_digit[a-4]};
        else                       return 32'h0;
    endfunction

    // Called after the write edge, so edge_cnt is that edge's number
    task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d);
        if (a == 0) begin
            if (!m_ctrl[2] && d[2]) scan_ref = edge_cnt;
            m_ctrl = d[2:0];
        end
        else if (a == 1)          m_blank = d[3:0];
        else if (a == 2)          m_blink = d[3:0];
        else if (a == 3)          m_mode  = d[3:0];
        else if (a >= 4 && a < 8) m_digit[a-4] = d[6:0];
    endtask

    // Compare all display outputs against the model; valid once a write is >= 1 edge old
    task automatic check_outputs(input string name);
        logic [7*N-1:0] exp;
        logic [6:0]     lit;
        logic [N-1:0]   exp_sel;
        logic [6:0]     exp_sseg;
        int             ph, idx;
        ph = (edge_cnt == 0) ? 0 : ((edge_cnt - 1) / BD) % 2;
        for (int i = 0; i < N; i++) begin
            if (!m_ctrl[0] || m_blank[i] || (m_ctrl[1] && m_blink[i] && ph == 1)) lit = 7'h00;
            else if (m_mode[i]) lit = glyph(m_digit[i][3:0]);
            else                lit = m_digit[i];
            exp[7*i +: 7] = ~lit;
        end
        if (m_ctrl[2]) begin
            idx      = ((edge_cnt - scan_ref) / SD) % N;
            exp_sel  = ~(4'b0001 << idx);
            exp_sseg = exp[7*idx +: 7];
        end else begin
            exp_sel  = 4'hF;
            exp_sseg = 7'h7F;
        end
        check({name, "_seg_out"}, seg_out, exp);
        check({name, "_scan_sel"}, scan_sel, exp_sel);
        check({name, "_scan_seg"}, scan_seg, exp_sseg);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string name);
        repeat (n) begin
            tick();
            check_outputs(name);
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
        model_write(a, d);
    endtask

    task automatic bus_read(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        check({name, "_valid"}, avs_readdatavalid, 1'b1);
        check({name, "_data"}, avs_readdata, exp);
        check_outputs(name);
        tick();
        check({name, "_valid_drop"}, avs_readdatavalid, 1'b0);
        check_outputs(name);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [31:0]   d;
        vecs[0] = '{5'd1,  32'hFFFF_FFF5, 32'h0000_0005};
        vecs[1] = '{5'd2,  32'h1234_5672, 32'h0000_0002};
        vecs[2] = '{5'd3,  32'hFFFF_FFFA, 32'h0000_000A};
        vecs[3] = '{5'd4,  32'hFFFF_FF85, 32'h0000_0005};
        vecs[4] = '{5'd5,  32'h0000_00FF, 32'h0000_007F};
        vecs[5] = '{5'd7,  32'hABCD_EF49, 32'h0000_0049};
        vecs[6] = '{5'd0,  32'hFFFF_FFFB, 32'h0000_0003};
        vecs[7] = '{5'd0,  32'h0000_0005, 32'h0000_0005};
        vecs[8] = '{5'd31, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9] = '{5'd8,  32'h0000_0001, 32'h0000_0000};

        // Reset state
        do_reset();
        check("rst_seg_out", seg_out, 28'h8102040);
        check("rst_scan_sel", scan_sel, 4'b1110);
        check("rst_scan_seg", scan_seg, 7'h40);
        check("rst_rvalid", avs_readdatavalid, 1'b0);
        check("rst_rdata", avs_readdata, 32'h0);
        idle(2, "rst_idle");
        bus_read(5'd0, 32'h5, "rst_ctrl_rd");

        // Hex then raw on digit 3
        bus_write(5'd7, 32'hA);
        check("hex_a_latency", seg_out[27:21], 7'h40);
        tick();
        check("hex_a", seg_out[27:21], 7'h08);
        check_outputs("hex_a");
        bus_write(5'd3, 32'hF7);
        bus_write(5'd7, 32'h49);
        tick();
        check("raw_49", seg_out[27:21], 7'h36);
        check_outputs("raw_49");

        // Blink on digit 0, then blink disabled
        bus_write(5'd3, 32'hF);
        for (int i = 0; i < N; i++) bus_write(5'(4 + i), 32'(i + 1));
        bus_write(5'd2, 32'h1);
        bus_write(5'd0, 32'h7);
        idle(16, "blink_on");
        bus_write(5'd0, 32'h5);
        idle(8, "blink_off");

        // Scan walk, scan disabled, scan restart
        idle(24, "scan_walk");
        bus_write(5'd0, 32'h1);
        idle(3, "scan_off");
        check("scan_off_sel", scan_sel, 4'hF);
        bus_write(5'd0, 32'h5);
        idle(15, "scan_restart");

        // Register vectors, including masking and unmapped offsets
        for (int v = 0; v < 10; v++) begin
            bus_write(vecs[v].addr, vecs[v].wdata);
            idle(1, "vec_idle");
            bus_read(vecs[v].addr, vecs[v].rexp, $sformatf("vec%0d", v));
        end
        for (int r = 0; r < 8; r++) bus_read(5'(r), model_read(5'(r)), $sformatf("after31_r%0d", r));

        // Read and write together: old value returned
        bus_write(5'd1, 32'h0);
        avs_address   = 5'd1;
        avs_writedata = 32'h3;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        tick();
        avs_write     = 1'b0;
        avs_read      = 1'b0;
        check("rw_valid", avs_readdatavalid, 1'b1);
        check("rw_old", avs_readdata, 32'h0);
        model_write(5'd1, 32'h3);
        bus_read(5'd1, 32'h3, "rw_new");

        // Reset overrides a concurrent access
        reset_n       = 1'b0;
        avs_address   = 5'd1;
        avs_writedata = 32'hF;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        tick();
        avs_write     = 1'b0;
        avs_read      = 1'b0;
        check("rst_wr_rvalid", avs_readdatavalid, 1'b0);
        reset_n = 1'b1;
        model_reset();
        bus_read(5'd1, 32'h0, "rst_wr_blank");

        // Randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            a = 5'($urandom_range(0, 9));
            if (a > 5'd7) a = 5'($urandom_range(8, 31));
            d = $urandom;
            bus_write(a, d);
            idle($urandom_range(1, 5), "rnd");
            if ($urandom_range(0, 1) == 1) begin
                a = 5'($urandom_range(0, 9));
                bus_read(a, model_read(a), "rnd_rd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
